// File: rtl/ublock_round_ctrl_if.sv
// Handshake bundle between the masked uBlock round sequencer and its host,
// LFSR, randomness source and datapath.
interface ublock_round_ctrl_if #(
   parameter int CNT_W = 5
);
   logic             start;
   logic             busy;
   logic             done;
   logic             done_ack;
   logic             lfsr_rst_n;
   logic             lfsr_step;
   logic             lfsr_first;
   logic             lfsr_last;
   logic             rnd_req;
   logic             rnd_ack;
   logic             dp_load;
   logic             dp_en;
   logic             dp_final;
   logic [CNT_W-1:0] round_cnt;
   logic             err;

   // Host side: requests work, supplies LFSR flags and randomness.
   modport master (
      output start, done_ack, lfsr_first, lfsr_last, rnd_ack,
      input  busy, done, lfsr_rst_n, lfsr_step, rnd_req,
             dp_load, dp_en, dp_final, round_cnt, err
   );

   // Sequencer side.
   modport slave (
      input  start, done_ack, lfsr_first, lfsr_last, rnd_ack,
      output busy, done, lfsr_rst_n, lfsr_step, rnd_req,
             dp_load, dp_en, dp_final, round_cnt, err
   );
endinterface

// File: rtl/ublock_round_ctrl.sv
// Round sequencer for the first-order masked uBlock core: per round it fetches
// fresh mask randomness, runs the masked datapath SBOX_LAT cycles, steps the LFSR.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | load masked shares, reload round-constant LFSR, clear round_cnt
// S_RAND  | request fresh randomness; check LFSR first flag on round 0
// S_ROUND | datapath enabled for SBOX_LAT cycles, then step LFSR or finish
// S_FINAL | output transform / share write-out
// S_DONE  | result valid until done_ack
// S_ERR   | fault detected; only rst leaves
module ublock_round_ctrl #(
   parameter int SBOX_LAT  = 2,
   parameter int ROUND_MAX = 24,
   parameter int CNT_W     = 5
) (
   input  logic               clk,
   input  logic               rst,
   ublock_round_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RAND  = 3'd2,
      S_ROUND = 3'd3,
      S_FINAL = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   localparam int               SUB_W      = 4;
   localparam logic [SUB_W-1:0] SUB_INIT   = SUB_W'(SBOX_LAT - 1);
   // round_cnt == ROUND_MAX-1 is the same test as round_cnt+1 == ROUND_MAX without overflow.
   localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUND_MAX - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
   logic [SUB_W-1:0] sub_q, sub_d;
   logic             step;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         round_cnt_q <= '0;
         sub_q       <= '0;
      end else begin
         state_q     <= state_d;
         round_cnt_q <= round_cnt_d;
         sub_q       <= sub_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      round_cnt_d = round_cnt_q;
      sub_d       = sub_q;
      step        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_LOAD;
         end
         S_LOAD: begin
            round_cnt_d = '0;
            state_d     = S_RAND;
         end
         S_RAND: begin
            if ((round_cnt_q == '0) && !bus.lfsr_first) begin
               state_d = S_ERR;
            end else if (bus.rnd_ack) begin
               sub_d   = SUB_INIT;
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            if (sub_q == '0) begin
               round_cnt_d = round_cnt_q + 1'b1;
               if (bus.lfsr_last) begin
                  state_d = S_FINAL;
               end else if (round_cnt_q == ROUND_LAST) begin
                  state_d = S_ERR;
               end else begin
                  step    = 1'b1;
                  state_d = S_RAND;
               end
            end else begin
               sub_d = sub_q - 1'b1;
            end
         end
         S_FINAL: state_d = S_DONE;
         S_DONE: begin
            if (bus.done_ack) state_d = S_IDLE;
         end
         S_ERR:   state_d = S_ERR;
         // Illegal encodings are treated as a fault.
         default: state_d = S_ERR;
      endcase
   end

   always_comb begin
      bus.busy       = (state_q == S_LOAD) || (state_q == S_RAND) ||
                       (state_q == S_ROUND) || (state_q == S_FINAL);
      bus.done       = (state_q == S_DONE);
      bus.rnd_req    = (state_q == S_RAND);
      bus.dp_load    = (state_q == S_LOAD);
      bus.dp_en      = (state_q == S_ROUND);
      bus.dp_final   = (state_q == S_FINAL);
      bus.err        = (state_q == S_ERR);
      bus.round_cnt  = round_cnt_q;
      bus.lfsr_rst_n = !(rst || (state_q == S_LOAD));
      bus.lfsr_step  = step && !rst;
   end

endmodule

// File: tb/tb_ublock_round_ctrl.sv
// Scoreboard bench for ublock_round_ctrl: an LFSR index model drives the round
// flags, per-run expectations are queued and checked when done or err rises.
module tb_ublock_round_ctrl;

   localparam int CNT_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ublock_round_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

   ublock_round_ctrl #(.SBOX_LAT(2), .ROUND_MAX(24), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      bit is_err;
      int lat;
      int rc;
      int steps;
      int ens;
      int loads;
      int finals;
      int reqs;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   int   idx = 0;
   bit   bad_first = 1'b0;
   bit   last_en = 1'b1;
   bit   stall_en = 1'b0;
   int   stall_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // LFSR model: index 0 holds the init constant, last round uses index 15.
   always @(posedge clk) begin
      if (!bus_if.lfsr_rst_n) idx <= 0;
      else if (bus_if.lfsr_step) idx <= idx + 1;
   end
   assign bus_if.lfsr_first = (idx == 0) && !bad_first;
   assign bus_if.lfsr_last  = (idx == 15) && last_en;

   // Randomness source: acks immediately, except a 3-cycle stall before round 5.
   initial begin
      bus_if.rnd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.dp_load) stall_cnt = 0;
         if (stall_en && idx == 4 && bus_if.rnd_req && stall_cnt < 3) begin
            bus_if.rnd_ack = 1'b0;
            stall_cnt++;
         end else begin
            bus_if.rnd_ack = 1'b1;
         end
      end
   end

   // Monitor: per-run statistics, LOAD cycle is cycle 1.
   int cyc = 0, m_steps = 0, m_ens = 0, m_loads = 0, m_finals = 0, m_reqs = 0, m_ovl = 0;
   bit done_prev = 1'b0, err_prev = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_if.dp_load) begin
            cyc = 1; m_steps = 0; m_ens = 0; m_loads = 0; m_finals = 0; m_reqs = 0; m_ovl = 0;
         end else begin
            cyc++;
         end
         m_steps  += int'(bus_if.lfsr_step);
         m_ens    += int'(bus_if.dp_en);
         m_loads  += int'(bus_if.dp_load);
         m_finals += int'(bus_if.dp_final);
         m_reqs   += int'(bus_if.rnd_req);
         m_ovl    += int'(bus_if.dp_en && bus_if.rnd_req);
         if ((bus_if.done && !done_prev) || (bus_if.err && !err_prev)) begin
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_output: done=%0b err=%0b with empty scoreboard", bus_if.done, bus_if.err);
            end else begin
               e = sb.pop_front();
               check("out_is_err", 32'(bus_if.err), 32'(e.is_err));
               check("latency",    32'(cyc),        32'(e.lat));
               check("round_cnt",  32'(bus_if.round_cnt), 32'(e.rc));
               check("lfsr_steps", 32'(m_steps),    32'(e.steps));
               check("dp_en_cyc",  32'(m_ens),      32'(e.ens));
               check("dp_loads",   32'(m_loads),    32'(e.loads));
               check("dp_finals",  32'(m_finals),   32'(e.finals));
               check("rnd_req_cyc",32'(m_reqs),     32'(e.reqs));
               check("en_req_ovl", 32'(m_ovl),      32'd0);
            end
         end
         done_prev = bus_if.done;
         err_prev  = bus_if.err;
      end
   end

   function automatic void push(input bit is_err, input int lat, input int rc, input int steps,
                                input int ens, input int finals, input int reqs);
      exp_t e;
      e.is_err = is_err; e.lat = lat; e.rc = rc; e.steps = steps;
      e.ens = ens; e.loads = 1; e.finals = finals; e.reqs = reqs;
      sb.push_back(e);
   endfunction

   task automatic pulse_start();
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
   endtask

   task automatic wait_out(input int budget);
      int n = 0;
      while (!(bus_if.done || bus_if.err) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!(bus_if.done || bus_if.err)) begin
         n_cmp++; n_err++;
         $display("FAIL timeout: no done/err within %0d cycles", budget);
      end
   endtask

   task automatic ack_done();
      bus_if.done_ack = 1'b1;
      @(negedge clk);
      bus_if.done_ack = 1'b0;
      check("done_after_ack", 32'(bus_if.done), 32'd0);
      check("busy_after_ack", 32'(bus_if.busy), 32'd0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [7:0] outs();
      return {bus_if.busy, bus_if.done, bus_if.rnd_req, bus_if.dp_load,
              bus_if.dp_en, bus_if.dp_final, bus_if.lfsr_step, bus_if.err};
   endfunction

   initial begin
      bus_if.start = 1'b0;
      bus_if.done_ack = 1'b0;
      @(negedge clk);
      check("rst_outs",       32'(outs()), 32'd0);
      check("rst_round_cnt",  32'(bus_if.round_cnt), 32'd0);
      check("rst_lfsr_rst_n", 32'(bus_if.lfsr_rst_n), 32'd0);
      do_reset(2);
      @(negedge clk);

      // Nominal: 16 rounds, latency 2 + 16*3 + 1.
      push(1'b0, 51, 16, 15, 32, 1, 16);
      pulse_start();
      wait_out(200);

      // Done held without ack; start during DONE is ignored.
      for (int i = 0; i < 10; i++) begin
         bus_if.start = (i == 3);
         @(negedge clk);
         check("done_hold", 32'(bus_if.done), 32'd1);
         check("no_restart", 32'(bus_if.busy), 32'd0);
      end
      bus_if.start = 1'b0;
      ack_done();
      @(negedge clk);

      // Randomness stall of 3 cycles before round 5.
      stall_en = 1'b1;
      push(1'b0, 54, 16, 15, 32, 1, 19);
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      check("load_lfsr_rst_n", 32'(bus_if.lfsr_rst_n), 32'd0);
      check("load_dp_load",    32'(bus_if.dp_load), 32'd1);
      wait_out(200);
      stall_en = 1'b0;
      ack_done();
      @(negedge clk);

      // Fault: LFSR not at its init constant in the first RAND.
      bad_first = 1'b1;
      push(1'b1, 3, 0, 0, 0, 0, 1);
      pulse_start();
      wait_out(50);
      for (int i = 0; i < 5; i++) begin
         bus_if.start = (i == 1);
         @(negedge clk);
         check("err_sticky", 32'(bus_if.err), 32'd1);
      end
      bus_if.start = 1'b0;
      bad_first = 1'b0;
      do_reset(1);
      check("err_cleared", 32'(bus_if.err), 32'd0);
      @(negedge clk);

      // Fault: lfsr_last never seen, runaway after 24 rounds.
      last_en = 1'b0;
      push(1'b1, 74, 24, 23, 48, 0, 24);
      pulse_start();
      wait_out(300);
      last_en = 1'b1;
      do_reset(1);
      @(negedge clk);

      // Reset during ROUND of round 7 aborts with no done pulse.
      begin
         int n = 0;
         pulse_start();
         while (!(idx == 6 && bus_if.dp_en) && n < 200) begin
            @(negedge clk);
            n++;
         end
         check("reached_round7", 32'(idx == 6 && bus_if.dp_en), 32'd1);
      end
      rst = 1'b1;
      #1;
      check("midrst_lfsr_rst_n", 32'(bus_if.lfsr_rst_n), 32'd0);
      @(negedge clk);
      check("midrst_outs",      32'(outs()), 32'd0);
      check("midrst_round_cnt", 32'(bus_if.round_cnt), 32'd0);
      check("midrst_lfsr_rst_n2", 32'(bus_if.lfsr_rst_n), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      push(1'b0, 51, 16, 15, 32, 1, 16);
      pulse_start();
      wait_out(200);
      ack_done();
      repeat (3) @(negedge clk);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
